// File: rtl/qarb_pkg.sv
// Shared types, defaults and the round-robin pick helper for the queue arbiters.
// Latency: none (declarations and a pure combinational function).
// Backpressure: not applicable; the optional build macro QARB_HIPRI_EN is read by queue_enq_arbiter.
package qarb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } qarb_state_e;

  localparam int QARB_NREQ      = 4;
  localparam int QARB_DWIDTH    = 32;
  localparam int QARB_Q_DEPTH   = 8;
  localparam int QARB_PTR_W     = 3;
  localparam int QARB_BURST_MAX = 4;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping modulo nreq (nreq <= 8).
  // Scanning offsets downward lets the smallest offset overwrite the rest.
  function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                       input int nreq = 8);
    rr_pick_t   res;
    logic [3:0] pos;
    res = '0;
    pos = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < nreq) begin
        pos = {1'b0, ptr} + 4'(k);
        if (pos >= 4'(nreq)) pos = pos - 4'(nreq);
        if (req[pos[2:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[2:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/qarb_rr_pick.sv
// Round-robin winner select: rotate req by ptr, priority-encode, rotate the index back.
// Latency: purely combinational.
// Backpressure: none; found_o low means nobody is requesting.
module qarb_rr_pick import qarb_pkg::*; #(
  parameter int NREQ = QARB_NREQ
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [2:0]      idx_o,
  output logic            found_o
);

  rr_pick_t pick;

  // Winner search starting at ptr_i and wrapping within NREQ requesters.
  always_comb begin
    pick = rr_pick(8'(req_i), ptr_i, NREQ);
  end

  assign idx_o   = pick.idx;
  assign found_o = pick.found;

endmodule

// File: rtl/queue_enq_arbiter.sv
// Round-robin, credit-tracked arbiter sharing one queue enqueue port; optional macro QARB_HIPRI_EN
// gives requester 0 strict priority in IDLE. Latency: ack is combinational, q_enq/q_din follow one cycle later.
// Backpressure: no ack while credits==0; requests stay pending until credits return via q_deq.
module queue_enq_arbiter import qarb_pkg::*; #(
  parameter int NREQ          = QARB_NREQ,
  parameter int DWIDTH        = QARB_DWIDTH,
  parameter int Q_DEPTH       = QARB_Q_DEPTH,
  parameter int POINTER_WIDTH = QARB_PTR_W,
  parameter int BURST_MAX     = QARB_BURST_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          ack,
  output logic                     q_enq,
  output logic [DWIDTH-1:0]        q_din,
  input  logic                     q_deq,
  output logic [POINTER_WIDTH:0]   credits,
  output logic [2:0]               grant_id,
  output logic                     cred_err
);

  localparam int CW = POINTER_WIDTH + 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX + 1) : 1;
  localparam logic [0:0]    ST_IDLE  = IDLE;
  localparam logic [0:0]    ST_BURST = BURST;
  localparam logic [BW-1:0] BEAT_ONE = BW'(1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_MAX);

  logic [0:0]        state_q, state_d;
  logic [2:0]        owner_q, owner_d;
  logic [BW-1:0]     beats_q, beats_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic              cred_err_q, cred_err_d;
  logic [2:0]        grant_id_q, grant_id_d;
  logic              q_enq_q;
  logic [DWIDTH-1:0] q_din_q;

  logic              pick_found, idle_found;
  logic [2:0]        pick_idx, idle_idx;
  logic              idle_last, own_req, own_last, has_credit;
  logic              win_vld, release_grant;
  logic [2:0]        win_idx, rel_idx;
  logic [DWIDTH-1:0] din_sel;

  function automatic logic [2:0] ptr_after(input logic [2:0] w);
    return (w == 3'(NREQ - 1)) ? 3'd0 : w + 3'd1;
  endfunction

  qarb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign has_credit = (credits_q != '0);

  // IDLE-state candidate: round-robin pick, optionally overridden by requester 0.
  always_comb begin
    idle_idx   = pick_idx;
    idle_found = pick_found;
`ifdef QARB_HIPRI_EN
    if (req[0]) begin
      idle_idx   = 3'd0;
      idle_found = 1'b1;
    end
`endif
  end

  // Look up request/last flags of the IDLE candidate and of the burst owner.
  always_comb begin
    idle_last = 1'b0;
    own_req   = 1'b0;
    own_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == idle_idx) idle_last = req_last[i];
      if (3'(i) == owner_q) begin
        own_req  = req[i];
        own_last = req_last[i];
      end
    end
  end

  // Grant FSM: pick a winner, open/close the burst lock, advance the round-robin pointer.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    beats_d       = beats_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    win_vld       = 1'b0;
    win_idx       = '0;
    release_grant = 1'b0;
    rel_idx       = owner_q;
    if (state_q == ST_IDLE) begin
      if (idle_found && has_credit) begin
        win_vld = 1'b1;
        win_idx = idle_idx;
        if (idle_last || BURST_MAX == 1) begin
          release_grant = 1'b1;
          rel_idx       = idle_idx;
        end else begin
          state_d = ST_BURST;
          owner_d = idle_idx;
          beats_d = BEAT_ONE;
        end
      end
    end else begin
      if (!own_req) begin
        // Owner let go of its request: the lock is released without a beat.
        state_d       = ST_IDLE;
        release_grant = 1'b1;
      end else if (has_credit) begin
        win_vld = 1'b1;
        win_idx = owner_q;
        beats_d = beats_q + BEAT_ONE;
        if (own_last || (beats_q + BEAT_ONE) == BEAT_MAX) begin
          state_d       = ST_IDLE;
          release_grant = 1'b1;
        end
      end
    end
    if (rst) win_vld = 1'b0;
    if (win_vld) grant_id_d = win_idx;
    if (release_grant) begin
      rr_ptr_d = ptr_after(rel_idx);
`ifdef QARB_HIPRI_EN
      // The priority requester never moves the round-robin pointer.
      if (rel_idx == 3'd0) rr_ptr_d = rr_ptr_q;
`endif
    end
  end

  // One-hot ack and the data of the accepted beat.
  always_comb begin
    ack     = '0;
    din_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == win_idx) begin
        ack[i]  = win_vld;
        din_sel = req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Free-slot accounting; a dequeue at full credit saturates and latches the error.
  always_comb begin
    credits_d  = credits_q;
    cred_err_d = cred_err_q;
    case ({win_vld, q_deq})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CW'(Q_DEPTH)) cred_err_d = 1'b1;
        else                           credits_d  = credits_q + CW'(1);
      end
      default: ;
    endcase
  end

  // State registers and the registered enqueue port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      beats_q    <= '0;
      rr_ptr_q   <= '0;
      credits_q  <= CW'(Q_DEPTH);
      cred_err_q <= 1'b0;
      grant_id_q <= '0;
      q_enq_q    <= 1'b0;
      q_din_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beats_q    <= beats_d;
      rr_ptr_q   <= rr_ptr_d;
      credits_q  <= credits_d;
      cred_err_q <= cred_err_d;
      grant_id_q <= grant_id_d;
      q_enq_q    <= win_vld;
      if (win_vld) q_din_q <= din_sel;
    end
  end

  assign q_enq    = q_enq_q;
  assign q_din    = q_din_q;
  assign credits  = credits_q;
  assign grant_id = grant_id_q;
  assign cred_err = cred_err_q;

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Self-checking bench for queue_enq_arbiter: vector table, directed corner sequences,
// then random traffic compared against a behavioural model of the arbitration rules.
module tb_queue_enq_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int QD   = 8;
  localparam int BM   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   ack;
  logic              q_enq;
  logic [DW-1:0]     q_din;
  logic              q_deq = 1'b0;
  logic [3:0]        credits;
  logic [2:0]        grant_id;
  logic              cred_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  queue_enq_arbiter #(
    .NREQ(NREQ), .DWIDTH(DW), .Q_DEPTH(QD), .POINTER_WIDTH(3), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .q_enq(q_enq), .q_din(q_din), .q_deq(q_deq),
    .credits(credits), .grant_id(grant_id), .cred_err(cred_err)
  );

  typedef struct {
    logic [3:0]  r;
    logic [3:0]  l;
    logic        d;
    logic [3:0]  ack;
    logic [3:0]  cred;
    logic        enq;
    logic [31:0] din;
  } vec_t;

  vec_t tbl[10];

  // Behavioural model state: lock owner (-1 = none), beats in lock, pointer, credits.
  int          m_owner, m_beats, m_ptr, m_cred, m_gid;
  bit          m_err, m_enq;
  logic [31:0] m_din;
  int          rem[NREQ];
  bit          pend[NREQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; req_last = '0; q_deq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic d);
    @(posedge clk); #1;
    req = r; req_last = l; q_deq = d;
    @(negedge clk);
  endtask

  function automatic int m_ptr_after(input int w);
`ifdef QARB_HIPRI_EN
    if (w == 0) return m_ptr;
`endif
    return (w + 1) % NREQ;
  endfunction

  function automatic int model_pick(input logic [3:0] r);
    if (m_cred == 0) return -1;
    if (m_owner >= 0) return r[m_owner] ? m_owner : -1;
`ifdef QARB_HIPRI_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++)
      if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic void model_step(input int w);
    int nc;
    if (w >= 0) begin
      m_enq = 1'b1;
      m_din = req_data[w*DW +: DW];
      m_gid = w;
      if (m_owner < 0) begin
        if (req_last[w] || BM == 1) m_ptr = m_ptr_after(w);
        else begin m_owner = w; m_beats = 1; end
      end else begin
        m_beats++;
        if (req_last[w] || m_beats == BM) begin
          m_ptr = m_ptr_after(w);
          m_owner = -1;
        end
      end
    end else begin
      m_enq = 1'b0;
      if (m_owner >= 0 && !req[m_owner]) begin
        m_ptr = m_ptr_after(m_owner);
        m_owner = -1;
      end
    end
    nc = m_cred - ((w >= 0) ? 1 : 0) + (q_deq ? 1 : 0);
    if (nc > QD) begin nc = QD; m_err = 1'b1; end
    m_cred = nc;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_exp[4];
    logic [3:0] e;
    int w;

`ifdef QARB_HIPRI_EN
    tbl[0] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd8, 1'b0, 32'h0};
    tbl[1] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd7, 1'b1, 32'hD000_0000};
    tbl[2] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd6, 1'b1, 32'hD000_0000};
    tbl[3] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd5, 1'b1, 32'hD000_0000};
    tbl[4] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd4, 1'b1, 32'hD000_0000};
    tbl[5] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd3, 1'b1, 32'hD000_0000};
    tbl[6] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd2, 1'b1, 32'hD000_0000};
    tbl[7] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd1, 1'b1, 32'hD000_0000};
    tbl[8] = '{4'hF, 4'hF, 1'b0, 4'h0, 4'd0, 1'b1, 32'hD000_0000};
    tbl[9] = '{4'h4, 4'h4, 1'b0, 4'h0, 4'd0, 1'b0, 32'hD000_0000};
    rr_exp = '{4'h1, 4'h1, 4'h1, 4'h1};
`else
    tbl[0] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd8, 1'b0, 32'h0};
    tbl[1] = '{4'hF, 4'hF, 1'b0, 4'h2, 4'd7, 1'b1, 32'hD000_0000};
    tbl[2] = '{4'hF, 4'hF, 1'b0, 4'h4, 4'd6, 1'b1, 32'hD000_0001};
    tbl[3] = '{4'hF, 4'hF, 1'b0, 4'h8, 4'd5, 1'b1, 32'hD000_0002};
    tbl[4] = '{4'hF, 4'hF, 1'b0, 4'h1, 4'd4, 1'b1, 32'hD000_0003};
    tbl[5] = '{4'hF, 4'hF, 1'b0, 4'h2, 4'd3, 1'b1, 32'hD000_0000};
    tbl[6] = '{4'hF, 4'hF, 1'b0, 4'h4, 4'd2, 1'b1, 32'hD000_0001};
    tbl[7] = '{4'hF, 4'hF, 1'b0, 4'h8, 4'd1, 1'b1, 32'hD000_0002};
    tbl[8] = '{4'hF, 4'hF, 1'b0, 4'h0, 4'd0, 1'b1, 32'hD000_0003};
    tbl[9] = '{4'h4, 4'h4, 1'b0, 4'h0, 4'd0, 1'b0, 32'hD000_0003};
    rr_exp = '{4'h1, 4'h8, 4'h1, 4'h8};
`endif

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_enq", 64'(q_enq), 64'(0));
    chk("rst_din", 64'(q_din), 64'(0));
    chk("rst_credits", 64'(credits), 64'(QD));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_cred_err", 64'(cred_err), 64'(0));

    // All four requesting single beats until credits run out
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
    for (int k = 0; k < 10; k++) begin
      cyc(tbl[k].r, tbl[k].l, tbl[k].d);
      chk($sformatf("tbl%0d_ack", k), 64'(ack), 64'(tbl[k].ack));
      chk($sformatf("tbl%0d_credits", k), 64'(credits), 64'(tbl[k].cred));
      chk($sformatf("tbl%0d_enq", k), 64'(q_enq), 64'(tbl[k].enq));
      chk($sformatf("tbl%0d_din", k), 64'(q_din), 64'(tbl[k].din));
    end

    // One returned credit lets the waiting requester 2 through
    cyc(4'h4, 4'h4, 1'b1);
    chk("cred0_ack", 64'(ack), 64'(0));
    chk("cred0_credits", 64'(credits), 64'(0));
    cyc(4'h4, 4'h4, 1'b0);
    chk("cred1_ack", 64'(ack), 64'(4'h4));
    chk("cred1_credits", 64'(credits), 64'(1));
    cyc(4'h0, 4'h0, 1'b0);
    chk("cred2_ack", 64'(ack), 64'(0));
    chk("cred2_credits", 64'(credits), 64'(0));
    chk("cred2_din", 64'(q_din), 64'(32'hD000_0002));

    // Three-beat burst from requester 1 while requester 3 waits
    do_reset();
    req_data[3*DW +: DW] = 32'hB300;
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      req = 4'b1010; q_deq = 1'b0;
      req_last = {1'b1, 1'b0, (b == 2), 1'b0};
      req_data[DW +: DW] = 32'hB100 + 32'(b);
      @(negedge clk);
      chk($sformatf("burst_b%0d_ack", b), 64'(ack), 64'(4'b0010));
      if (b > 0) chk($sformatf("burst_b%0d_din", b), 64'(q_din), 64'(32'hB100 + 32'(b - 1)));
    end
    cyc(4'b1000, 4'b1000, 1'b0);
    chk("burst_next_ack", 64'(ack), 64'(4'b1000));
    chk("burst_last_din", 64'(q_din), 64'(32'hB102));
    cyc(4'h0, 4'h0, 1'b0);
    chk("burst_r3_din", 64'(q_din), 64'(32'hB300));
    chk("burst_r3_gid", 64'(grant_id), 64'(3));

    // Requester 0 never marks last: lock ends after BURST_MAX beats
    do_reset();
    for (int b = 0; b < BM; b++) begin
      cyc(4'b0101, 4'b0000, 1'b0);
      chk($sformatf("bmax_b%0d_ack", b), 64'(ack), 64'(4'b0001));
    end
`ifdef QARB_HIPRI_EN
    cyc(4'b0101, 4'b0101, 1'b0);
    chk("bmax_after_ack", 64'(ack), 64'(4'b0001));
    cyc(4'b0100, 4'b0100, 1'b0);
    chk("bmax_wrap_ack", 64'(ack), 64'(4'b0100));
`else
    cyc(4'b0101, 4'b0100, 1'b0);
    chk("bmax_after_ack", 64'(ack), 64'(4'b0100));
    cyc(4'b0001, 4'b0001, 1'b0);
    chk("bmax_wrap_ack", 64'(ack), 64'(4'b0001));
`endif
    chk("bmax_credits", 64'(credits), 64'(3));

    // Simultaneous accept/dequeue, then overflow at full credit
    do_reset();
    for (int b = 0; b < 3; b++) cyc(4'h1, 4'h1, 1'b0);
    cyc(4'h1, 4'h1, 1'b1);
    chk("same_ack", 64'(ack), 64'(4'h1));
    chk("same_credits_before", 64'(credits), 64'(5));
    cyc(4'h0, 4'h0, 1'b0);
    chk("same_credits_after", 64'(credits), 64'(5));
    for (int k = 0; k < 4; k++) begin
      cyc(4'h0, 4'h0, 1'b1);
      chk($sformatf("deq%0d_credits", k), 64'(credits), 64'(5 + k));
      chk($sformatf("deq%0d_err", k), 64'(cred_err), 64'(0));
    end
    cyc(4'h0, 4'h0, 1'b0);
    chk("ovf_credits", 64'(credits), 64'(QD));
    chk("ovf_err", 64'(cred_err), 64'(1));
    cyc(4'h0, 4'h0, 1'b0);
    chk("ovf_err_sticky", 64'(cred_err), 64'(1));

    // Requesters 0 and 3 competing continuously
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1001, 4'b1001, 1'b0);
      chk($sformatf("rr%0d_ack", k), 64'(ack), 64'(rr_exp[k]));
    end
    cyc(4'h0, 4'h0, 1'b0);
`ifdef QARB_HIPRI_EN
    chk("rr_gid", 64'(grant_id), 64'(0));
`else
    chk("rr_gid", 64'(grant_id), 64'(3));
`endif

    // Reset in the middle of a burst abandons the lock
    do_reset();
    cyc(4'h1, 4'h0, 1'b0);
    cyc(4'h1, 4'h0, 1'b0);
    chk("mid_b2_ack", 64'(ack), 64'(4'h1));
    @(posedge clk); #1;
    rst = 1'b1; req = 4'h1; req_last = 4'h0;
    @(negedge clk);
    chk("mid_rst_ack", 64'(ack), 64'(0));
    chk("mid_rst_enq_kept", 64'(q_enq), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0; req = 4'h1; req_last = 4'h1;
    @(negedge clk);
    chk("mid_after_enq", 64'(q_enq), 64'(0));
    chk("mid_after_credits", 64'(credits), 64'(QD));
    chk("mid_after_gid", 64'(grant_id), 64'(0));
    chk("mid_after_ack", 64'(ack), 64'(4'h1));

    // Random traffic against the behavioural model
    do_reset();
    m_owner = -1; m_beats = 0; m_ptr = 0; m_cred = QD; m_gid = 0;
    m_err = 1'b0; m_enq = 1'b0; m_din = '0;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; pend[i] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          req[i] = 1'b0;
          req_last[i] = 1'b0;
          if (rem[i] == 0 && $urandom_range(0, 99) < 30) rem[i] = $urandom_range(1, 6);
          if (rem[i] > 0 && $urandom_range(0, 99) < 85) begin
            pend[i] = 1'b1;
            req[i] = 1'b1;
            req_last[i] = (rem[i] == 1);
            req_data[i*DW +: DW] = $urandom;
          end
        end
      end
      q_deq = (m_cred < QD) && ($urandom_range(0, 99) < 45);
      @(negedge clk);
      w = model_pick(req);
      e = '0;
      if (w >= 0) e[w] = 1'b1;
      chk("rand_ack", 64'(ack), 64'(e));
      chk("rand_enq", 64'(q_enq), 64'(m_enq));
      chk("rand_din", 64'(q_din), 64'(m_din));
      chk("rand_credits", 64'(credits), 64'(m_cred));
      chk("rand_gid", 64'(grant_id), 64'(m_gid));
      chk("rand_err", 64'(cred_err), 64'(m_err));
      model_step(w);
      if (w >= 0) begin
        pend[w] = 1'b0;
        rem[w]--;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_enq_arbiter.md
Name: queue_enq_arbiter

Overview:
- Round-robin arbiter that shares one enqueue port of the team's 8-deep, 32-bit queue between NREQ requesters.
- Tracks free queue slots with a credit counter, so it never issues an enqueue into a full queue and never relies on the queue's combinational full flag.
- Supports short locked bursts so one requester's multi-word message lands contiguously.
- Sits between the requesters and the queue's enq/din/deq pins.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DWIDTH, 32, data width; matches the queue
- Q_DEPTH, 8, queue depth = initial credit count
- POINTER_WIDTH, 3, log2(Q_DEPTH); credit counter is POINTER_WIDTH+1 bits
- BURST_MAX, 4, maximum beats per locked burst (1 disables bursts)

Ports:
- clk, input, 1, single clock, rising edge
- rst, input, 1, synchronous, active-high reset
- req, input, NREQ, per-requester request; held until acked
- req_data, input, NREQ*DWIDTH, requester i data in bits [i*DWIDTH +: DWIDTH]
- req_last, input, NREQ, marks the final beat of a burst
- ack, output, NREQ, combinational one-hot grant; beat accepted this cycle
- q_enq, output, 1, registered enqueue strobe to the queue
- q_din, output, DWIDTH, registered enqueue data
- q_deq, input, 1, the queue's dequeue strobe (one slot freed)
- credits, output, POINTER_WIDTH+1, free-slot count
- grant_id, output, 3, index of the last winner
- cred_err, output, 1, sticky flag: credit overflow

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, credits=Q_DEPTH, rr_ptr=0, q_enq=0, q_din=0, grant_id=0, cred_err=0; ack=0 while rst is high.
- Accept condition: credits>0. ack is combinational from state, req, rr_ptr and credits.
- Latency: the beat acked in cycle T appears on q_enq/q_din in cycle T+1. If no beat is acked, q_enq=0 next cycle and q_din holds its value.
- IDLE: the winner is the first asserted req searching upward from rr_ptr, wrapping modulo NREQ. On accept: ack[w]=1, grant_id<=w.
  - req_last[w]=1 or BURST_MAX=1: rr_ptr<=(w+1)%NREQ; stay in IDLE.
  - Otherwise: state<=BURST, owner<=w, beats<=1.
- BURST: only the owner can be acked.
  - Owner beat accepted: beats++.
  - Exit to IDLE with rr_ptr<=(owner+1)%NREQ when any of:
    - the accepted beat has req_last=1
    - beats reaches BURST_MAX on an accepted beat
    - req[owner] is low for a cycle (lock released; no ack that cycle)
  - credits==0 with owner requesting: hold BURST and stall; no ack.
- Credits:
  - Accept and no q_deq: credits-1.
  - q_deq and no accept: credits+1.
  - Both in the same cycle: unchanged.
  - q_deq when credits==Q_DEPTH: count saturates and cred_err<=1 (sticky until rst).
- credits==0: no ack in any state. Requesters keep requesting; none is lost.
- Reset mid-burst: the lock is abandoned. The in-flight q_enq is dropped only if rst is asserted in the cycle that would drive it; the queue must be reset together with the arbiter.
- Every requester is served within NREQ*BURST_MAX accepted beats, provided credits return.

Optional Feature:
- Macro: QARB_HIPRI_EN.
- Defined: requester 0 has strict priority in IDLE.
  - If req[0]=1 it wins regardless of rr_ptr, and rr_ptr is not updated when 0 wins.
  - Requester 0 cannot preempt an active BURST owned by another requester.
- Undefined: pure round-robin as above; requester 0 is treated like the others.

Decomposition:
- Package qarb_pkg:
  - state enum: IDLE=1'b0, BURST=1'b1
  - default-width localparams
  - function rr_pick(req, ptr), returning the winner index and a found flag
- One sub-module, qarb_rr_pick: combinational rotate/priority-encode/unrotate of req by rr_ptr. It is reused by the dequeue-side scheduler.
- The credit counter and FSM stay in the top module.

Test Plan:
- Reset, then req=4'b1111 with req_last=1111, no q_deq: acks go 0,1,2,3,0,1,2,3 over 8 cycles; credits falls 8→0; the 9th cycle has no ack. q_din carries each requester's data one cycle after its ack.
- credits=0, req[2] held: no ack. A single q_deq pulse → credits=1, ack[2] the next cycle, credits back to 0.
- Requester 1 bursts 3 beats with req_last on beat 3 while req[3] is also asserted: ack[1] for 3 consecutive cycles, then ack[3]. The queue receives the beats contiguously.
- BURST_MAX=4, requester 0 never asserts req_last, with req[2] asserted: the lock ends after 4 beats and ack[2] follows. Requester 0 regains the grant only after rr_ptr wraps.
- Accept and q_deq in the same cycle at credits=5 → credits stays 5. q_deq at credits=8 → cred_err=1 and credits stays 8.
- QARB_HIPRI_EN defined, req=4'b1001 continuously: requester 0 wins every IDLE arbitration. Undefined: grants alternate 0,3,0,3.
